// File: rtl/hydra_port_tx_if.sv
// hydra_port_tx_if -- bundle of host-request, payload-source, switch-write and
// status signals for one hydra transmit port.
//
// Signals:
//   req, req_rdy, req_dest[3:0], req_prio[2:0], req_len[8:0]  packet request
//   src_data[15:0], src_vld, src_rdy                          payload source
//   wr_sop, wr_vld, wr_data[15:0], wr_eop                     switch write port
//   pause                                                     switch back-pressure
//   busy                                                      status
//
// Modports:
//   master -- host/switch side (drives requests, payload and pause)
//   slave  -- the transmit port itself
interface hydra_port_tx_if;
    logic        req;
    logic        req_rdy;
    logic [3:0]  req_dest;
    logic [2:0]  req_prio;
    logic [8:0]  req_len;
    logic [15:0] src_data;
    logic        src_vld;
    logic        src_rdy;
    logic        wr_sop;
    logic        wr_vld;
    logic [15:0] wr_data;
    logic        wr_eop;
    logic        pause;
    logic        busy;

    modport master (
        output req, req_dest, req_prio, req_len, src_data, src_vld, pause,
        input  req_rdy, src_rdy, wr_sop, wr_vld, wr_data, wr_eop, busy
    );

    modport slave (
        input  req, req_dest, req_prio, req_len, src_data, src_vld, pause,
        output req_rdy, src_rdy, wr_sop, wr_vld, wr_data, wr_eop, busy
    );
endinterface

// File: rtl/hydra_port_tx.sv
// hydra_port_tx -- transmit port that turns a host packet request plus a stream
// of payload words into a framed write sequence for the switch:
// wr_sop, one header word {len, prio, dest}, len payload words, wr_eop.
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of hydra_port_tx_if (request, payload source,
//          switch write port, pause, busy)
//
// Configuration:
//   HYDRA_TX_PAUSE_STALL_EN  when defined, pause also stalls the payload phase
//                            (src_rdy forced low while pause=1). When undefined,
//                            pause only gates packet start.
module hydra_port_tx (
    input  logic            clk,
    input  logic            rst_n,
    hydra_port_tx_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StSop, StHead, StData, StEop} state_e;

    state_e      state_q;
    logic [8:0]  cnt_q;
    logic [8:0]  len_q;
    logic [2:0]  prio_q;
    logic [3:0]  dest_q;
    logic        wr_sop_q;
    logic        wr_vld_q;
    logic        wr_eop_q;
    logic [15:0] wr_data_q;

    logic        stall;
    logic        src_rdy;
    logic        xfer;

`ifdef HYDRA_TX_PAUSE_STALL_EN
    assign stall = bus.pause;
`else
    assign stall = 1'b0;
`endif

    // Ready stays low once all len words have been taken; that cycle shows the
    // last payload word and the FSM moves on to EOP.
    assign src_rdy = (state_q == StData) && (cnt_q != len_q) && !stall;
    assign xfer    = src_rdy && bus.src_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 9'd0;
            len_q     <= 9'd0;
            prio_q    <= 3'd0;
            dest_q    <= 4'd0;
            wr_sop_q  <= 1'b0;
            wr_vld_q  <= 1'b0;
            wr_eop_q  <= 1'b0;
            wr_data_q <= 16'd0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            wr_sop_q <= 1'b0;
            wr_vld_q <= 1'b0;
            wr_eop_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req && !bus.pause) begin
                        state_q  <= StSop;
                        dest_q   <= bus.req_dest;
                        prio_q   <= bus.req_prio;
                        len_q    <= bus.req_len;
                        cnt_q    <= 9'd0;
                        wr_sop_q <= 1'b1;
                    end
                end
                StSop: begin
                    state_q   <= StHead;
                    wr_vld_q  <= 1'b1;
                    wr_data_q <= {len_q, prio_q, dest_q};
                end
                StHead: begin
                    if (len_q == 9'd0) begin
                        state_q  <= StEop;
                        wr_eop_q <= 1'b1;
                    end else begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (xfer) begin
                        cnt_q     <= cnt_q + 9'd1;
                        wr_vld_q  <= 1'b1;
                        wr_data_q <= bus.src_data;
                    end else if (cnt_q == len_q) begin
                        state_q  <= StEop;
                        wr_eop_q <= 1'b1;
                    end
                end
                StEop: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_rdy = (state_q == StIdle) && !bus.pause;
    assign bus.src_rdy = src_rdy;
    assign bus.busy    = (state_q != StIdle);
    assign bus.wr_sop  = wr_sop_q;
    assign bus.wr_vld  = wr_vld_q;
    assign bus.wr_eop  = wr_eop_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_hydra_port_tx.sv
// tb_hydra_port_tx -- directed bench for hydra_port_tx. Inputs are driven 1 ns
// after the rising edge and outputs checked 2 ns after it.
module tb_hydra_port_tx;

`ifdef HYDRA_TX_PAUSE_STALL_EN
    localparam bit Stall = 1'b1;
`else
    localparam bit Stall = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    hydra_port_tx_if bus ();

    hydra_port_tx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mkword(input int i);
        return 16'(i * 241 + 14940);
    endfunction

    // One complete packet. pre: cycles of pause=1 with req held before release.
    // vmode 1 toggles src_vld starting high. Pause is raised for pl data-phase
    // cycles starting at data cycle ps. Returns src_rdy-low cycles seen before
    // the last transfer (gap) and the number of payload wr_vld cycles (nv).
    task automatic send_pkt(input int d, input int p, input int l, input int vmode,
                            input int ps, input int pl, input int pre,
                            input logic [15:0] hdr, output int gap, output int nv);
        int   sent;
        logic px;
        logic [15:0] pw;
        logic dn;
        logic exp_rdy;
        logic fin;
        gap = 0;
        nv  = 0;
        for (int k = 0; k < pre; k++) begin
            tick;
            bus.req = 1'b1; bus.req_dest = 4'(d); bus.req_prio = 3'(p);
            bus.req_len = 9'(l); bus.pause = 1'b1; bus.src_vld = 1'b0;
            #1;
            chk1("paused_req_rdy", bus.req_rdy, 1'b0);
            chk1("paused_wr_sop", bus.wr_sop, 1'b0);
            chk1("paused_busy", bus.busy, 1'b0);
        end
        tick;
        bus.req = 1'b1; bus.req_dest = 4'(d); bus.req_prio = 3'(p);
        bus.req_len = 9'(l); bus.pause = 1'b0; bus.src_vld = 1'b0;
        #1;
        chk1("accept_req_rdy", bus.req_rdy, 1'b1);
        chk1("accept_busy", bus.busy, 1'b0);
        tick;
        // Scramble fields: the header must come from the latched copy.
        bus.req = 1'b0; bus.req_dest = ~bus.req_dest; bus.req_prio = ~bus.req_prio;
        bus.req_len = ~bus.req_len;
        #1;
        chk1("sop_wr_sop", bus.wr_sop, 1'b1);
        chk1("sop_wr_vld", bus.wr_vld, 1'b0);
        chk1("sop_wr_eop", bus.wr_eop, 1'b0);
        chk1("sop_busy", bus.busy, 1'b1);
        chk1("sop_req_rdy", bus.req_rdy, 1'b0);
        tick;
        #1;
        chk1("head_wr_vld", bus.wr_vld, 1'b1);
        chk16("head_wr_data", bus.wr_data, hdr);
        chk1("head_wr_sop", bus.wr_sop, 1'b0);
        chk1("head_src_rdy", bus.src_rdy, 1'b0);
        if (l > 0) begin
            sent = 0;
            px   = 1'b0;
            pw   = 16'd0;
            fin  = 1'b0;
            for (int j = 0; j < 1100; j++) begin
                tick;
                bus.pause    = (j >= ps) && (j < ps + pl);
                bus.src_vld  = (vmode == 0) || (j % 2 == 0);
                bus.src_data = mkword(sent);
                #1;
                dn      = (sent == l);
                exp_rdy = !dn && !(Stall && bus.pause);
                chk1("data_src_rdy", bus.src_rdy, exp_rdy);
                chk1("data_wr_vld", bus.wr_vld, px);
                if (px) chk16("data_wr_data", bus.wr_data, pw);
                chk1("data_wr_eop", bus.wr_eop, 1'b0);
                chk1("data_wr_sop", bus.wr_sop, 1'b0);
                if (bus.wr_vld) nv++;
                if (!dn && !bus.src_rdy) gap++;
                px = exp_rdy && bus.src_vld;
                pw = bus.src_data;
                if (px) sent++;
                if (dn) begin
                    fin = 1'b1;
                    break;
                end
            end
            chk1("data_phase_done", fin, 1'b1);
        end
        bus.pause   = 1'b0;
        bus.src_vld = 1'b0;
        tick;
        #1;
        chk1("eop_wr_eop", bus.wr_eop, 1'b1);
        chk1("eop_wr_vld", bus.wr_vld, 1'b0);
        chk1("eop_wr_sop", bus.wr_sop, 1'b0);
        chk1("eop_busy", bus.busy, 1'b1);
        chk1("eop_src_rdy", bus.src_rdy, 1'b0);
        tick;
        #1;
        chk1("post_wr_eop", bus.wr_eop, 1'b0);
        chk1("post_busy", bus.busy, 1'b0);
        chk1("post_req_rdy", bus.req_rdy, 1'b1);
    endtask

    int gap;
    int nv;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.req = 1'b0; bus.req_dest = 4'd0; bus.req_prio = 3'd0; bus.req_len = 9'd0;
        bus.src_data = 16'd0; bus.src_vld = 1'b0; bus.pause = 1'b0;
        #2;
        chk1("rst_wr_sop", bus.wr_sop, 1'b0);
        chk1("rst_wr_vld", bus.wr_vld, 1'b0);
        chk1("rst_wr_eop", bus.wr_eop, 1'b0);
        chk16("rst_wr_data", bus.wr_data, 16'h0000);
        chk1("rst_src_rdy", bus.src_rdy, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        tick;
        tick;
        rst_n = 1'b1;

        // dest=3 prio=4 len=34, src_vld held high
        send_pkt(3, 4, 34, 0, 1000, 0, 0, 16'h1143, gap, nv);
        chkn("len34_vld_count", nv, 34);
        chkn("len34_gap", gap, 0);

        // empty packet
        send_pkt(10, 5, 0, 0, 1000, 0, 0, 16'h005A, gap, nv);

        // src_vld toggling, len=8
        send_pkt(1, 2, 8, 1, 1000, 0, 0, 16'h0421, gap, nv);
        chkn("len8_vld_count", nv, 8);

        // pause held for 10 cycles against a pending request
        send_pkt(7, 7, 1, 0, 1000, 0, 10, 16'h00F7, gap, nv);
        chkn("len1_vld_count", nv, 1);

        // pause for 5 cycles mid-payload, len=16
        send_pkt(12, 1, 16, 0, 4, 5, 0, 16'h081C, gap, nv);
        chkn("pause_gap", gap, Stall ? 5 : 0);
        chkn("pause_vld_count", nv, 16);

        // maximum length
        send_pkt(15, 7, 511, 0, 1000, 0, 0, 16'hFFFF, gap, nv);
        chkn("len511_vld_count", nv, 511);

        // reset at the 10th payload word of a len=34 packet
        tick;
        bus.req = 1'b1; bus.req_dest = 4'd5; bus.req_prio = 3'd3; bus.req_len = 9'd34;
        bus.src_vld = 1'b1;
        #1;
        chk1("rstpkt_req_rdy", bus.req_rdy, 1'b1);
        tick;
        bus.req = 1'b0;
        #1;
        chk1("rstpkt_wr_sop", bus.wr_sop, 1'b1);
        tick;
        #1;
        chk16("rstpkt_hdr", bus.wr_data, 16'h1135);
        for (int j = 0; j <= 10; j++) begin
            tick;
            bus.src_data = mkword(j);
        end
        #1;
        chk1("rstpkt_word10_vld", bus.wr_vld, 1'b1);
        chk16("rstpkt_word10_data", bus.wr_data, mkword(9));
        #1;
        rst_n = 1'b0;
        #1;
        chk1("midrst_wr_sop", bus.wr_sop, 1'b0);
        chk1("midrst_wr_vld", bus.wr_vld, 1'b0);
        chk1("midrst_wr_eop", bus.wr_eop, 1'b0);
        chk16("midrst_wr_data", bus.wr_data, 16'h0000);
        chk1("midrst_src_rdy", bus.src_rdy, 1'b0);
        chk1("midrst_busy", bus.busy, 1'b0);
        bus.src_vld = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick;
            #1;
            chk1("inrst_wr_eop", bus.wr_eop, 1'b0);
            chk1("inrst_busy", bus.busy, 1'b0);
        end
        tick;
        rst_n = 1'b1;
        tick;
        #1;
        chk1("relrst_wr_eop", bus.wr_eop, 1'b0);

        send_pkt(2, 6, 2, 0, 1000, 0, 0, 16'h0162, gap, nv);
        chkn("after_rst_vld_count", nv, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
